// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-requester arbiter for the unified RAM data port
module ram_arbiter #(
    parameter int ADDR_SIZE = 12,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [WORD_SIZE-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_ack,
    output logic [WORD_SIZE-1:0] m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [WORD_SIZE-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_ack,
    output logic [WORD_SIZE-1:0] m1_rdata,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_data_in,
    output logic                 ram_write_en,
    input  logic [WORD_SIZE-1:0] ram_data_out,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]           r_state;
    logic                 r_last_owner;
    logic                 r_m0_gnt;
    logic                 r_m1_gnt;
    logic                 r_m0_ack;
    logic                 r_m1_ack;
    logic [WORD_SIZE-1:0] r_m0_rdata;
    logic [WORD_SIZE-1:0] r_m1_rdata;
    logic [ADDR_SIZE-1:0] r_ram_addr;
    logic [WORD_SIZE-1:0] r_ram_data_in;
    logic                 r_ram_we;
    logic                 r_busy;

    logic                 w_idle_winner;
    logic                 w_other_req;
    logic                 w_issue;
    logic                 w_winner;
    logic                 w_win_we;
    logic [ADDR_SIZE-1:0] w_win_addr;
    logic [WORD_SIZE-1:0] w_win_wdata;

    // In RESP the owner's req is still the stale one, so only the other side may be issued.
    always_comb begin
        w_idle_winner = (m0_req && m1_req) ? ~r_last_owner : m1_req;
        w_other_req   = r_last_owner ? m0_req : m1_req;
        w_issue       = 1'b0;
        w_winner      = w_idle_winner;
        if (r_state == ST_IDLE) begin
            w_issue = m0_req || m1_req;
        end else if (r_state == ST_RESP) begin
            w_issue  = w_other_req;
            w_winner = ~r_last_owner;
        end
        w_win_we    = w_winner ? m1_we    : m0_we;
        w_win_addr  = w_winner ? m1_addr  : m0_addr;
        w_win_wdata = w_winner ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_owner  <= 1'b1;
            r_m0_gnt      <= 1'b0;
            r_m1_gnt      <= 1'b0;
            r_m0_ack      <= 1'b0;
            r_m1_ack      <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
            r_ram_we      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                ST_ACCESS: begin
                    // RAM completed its read on the negedge inside this cycle.
                    if (r_last_owner) begin
                        r_m1_rdata <= ram_data_out;
                        r_m1_ack   <= 1'b1;
                    end else begin
                        r_m0_rdata <= ram_data_out;
                        r_m0_ack   <= 1'b1;
                    end
                    r_m0_gnt <= 1'b0;
                    r_m1_gnt <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_IDLE, ST_RESP: begin
                    if (w_issue) begin
                        r_ram_addr    <= w_win_addr;
                        r_ram_data_in <= w_win_wdata;
                        r_ram_we      <= w_win_we;
                        r_m0_gnt      <= ~w_winner;
                        r_m1_gnt      <= w_winner;
                        r_last_owner  <= w_winner;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ACCESS;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_m0_gnt <= 1'b0;
                    r_m1_gnt <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_gnt       = r_m0_gnt;
    assign m1_gnt       = r_m1_gnt;
    assign m0_ack       = r_m0_ack;
    assign m1_ack       = r_m1_ack;
    assign m0_rdata     = r_m0_rdata;
    assign m1_rdata     = r_m1_rdata;
    assign ram_addr     = r_ram_addr;
    assign ram_data_in  = r_ram_data_in;
    assign ram_write_en = r_ram_we;
    assign busy         = r_busy;

endmodule
